// File: rtl/m_axis_pattern_gen.sv
// AXI4-Stream test-packet source: programmable length, packet count, gap and data pattern.
// All stream outputs are registered; tready only feeds next-state logic.
module m_axis_pattern_gen #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int GAP_W  = 8
) (
    input  logic              axi_clk,
    input  logic              axi_rst_L,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [1:0]        cfg_mode,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [15:0]       cfg_num_pkts,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic [DATA_W-1:0] cfg_pattern,
    output logic [DATA_W-1:0] axi_tdata,
    output logic              axi_tvalid,
    output logic              axi_tlast,
    input  logic              axi_tready,
    output logic              busy,
    output logic [15:0]       pkt_cnt
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    typedef struct packed {
        logic [1:0]        mode;
        logic [LEN_W-1:0]  len;
        logic [15:0]       num_pkts;
        logic [GAP_W-1:0]  gap;
        logic [DATA_W-1:0] pattern;
    } cfg_t;

    state_t            state_q, state_d;
    cfg_t              cfg_q, cfg_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [DATA_W-1:0] data_q, data_d, data_nxt, seed;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              stop_q, stop_d;
    logic [15:0]       pkt_q, pkt_d;
    logic              fire, run_done;

    assign fire     = valid_q & axi_tready;
    assign run_done = (cfg_q.num_pkts != 16'd0) && ((pkt_q + 16'd1) == cfg_q.num_pkts);

    // Seed for the first beat of a run, taken from the live cfg inputs.
    always_comb begin
        seed = '0;
        case (cfg_mode)
            2'd2:    seed = cfg_pattern;
            2'd3:    seed = DATA_W'(1);
            default: seed = '0;
        endcase
    end

    // Pattern value for the beat after the one currently being accepted.
    always_comb begin
        data_nxt = data_q;
        case (cfg_q.mode)
            2'd0:    data_nxt = data_q + DATA_W'(1);
            2'd1:    data_nxt = last_q ? '0 : data_q + DATA_W'(1);
            2'd2:    data_nxt = cfg_q.pattern;
            default: data_nxt = {data_q[DATA_W-2:0], data_q[DATA_W-1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        data_d  = data_q;
        pkt_d   = pkt_q;
        stop_d  = stop_q | (busy_q & cfg_stop);

        case (state_q)
            IDLE: begin
                if (cfg_start && cfg_len != '0) begin
                    cfg_d.mode     = cfg_mode;
                    cfg_d.len      = cfg_len;
                    cfg_d.num_pkts = cfg_num_pkts;
                    cfg_d.gap      = cfg_gap;
                    cfg_d.pattern  = cfg_pattern;
                    pkt_d          = '0;
                    beat_d         = '0;
                    data_d         = seed;
                    state_d        = SEND;
                end
            end
            SEND: begin
                if (fire) begin
                    data_d = data_nxt;
                    if (last_q) begin
                        pkt_d  = pkt_q + 16'd1;
                        beat_d = '0;
                        if (stop_q || cfg_stop || run_done) begin
                            state_d = IDLE;
                        end else if (cfg_q.gap != '0) begin
                            state_d = GAP;
                            gap_d   = cfg_q.gap;
                        end
                    end else begin
                        beat_d = beat_q + LEN_W'(1);
                    end
                end
            end
            GAP: begin
                if (stop_q || cfg_stop) begin
                    state_d = IDLE;
                end else if (gap_q <= GAP_W'(1)) begin
                    state_d = SEND;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) stop_d = 1'b0;

        // Output registers are loaded from the next state so they line up with it.
        valid_d = (state_d == SEND);
        busy_d  = (state_d != IDLE);
        last_d  = (state_d == SEND) && (beat_d == cfg_d.len - LEN_W'(1));
    end

    always_ff @(posedge axi_clk or negedge axi_rst_L) begin
        if (!axi_rst_L) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            beat_q  <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            stop_q  <= 1'b0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            stop_q  <= stop_d;
            pkt_q   <= pkt_d;
        end
    end

    assign axi_tdata  = data_q;
    assign axi_tvalid = valid_q;
    assign axi_tlast  = last_q;
    assign busy       = busy_q;
    assign pkt_cnt    = pkt_q;

endmodule

// File: tb/tb_m_axis_pattern_gen.sv
// Directed + randomized bench for m_axis_pattern_gen; expected beats come from
// an index-based model (beat number -> data/tlast) rather than a state machine.
module tb_m_axis_pattern_gen;

    logic        axi_clk = 1'b0;
    logic        axi_rst_L = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_stop = 1'b0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_len = '0;
    logic [15:0] cfg_num_pkts = '0;
    logic [7:0]  cfg_gap = '0;
    logic [31:0] cfg_pattern = '0;
    logic [31:0] axi_tdata;
    logic        axi_tvalid;
    logic        axi_tlast;
    logic        axi_tready = 1'b0;
    logic        busy;
    logic [15:0] pkt_cnt;

    int checks = 0;
    int errors = 0;

    m_axis_pattern_gen #(.DATA_W(32), .LEN_W(16), .GAP_W(8)) dut (
        .axi_clk(axi_clk), .axi_rst_L(axi_rst_L),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_mode(cfg_mode),
        .cfg_len(cfg_len), .cfg_num_pkts(cfg_num_pkts), .cfg_gap(cfg_gap),
        .cfg_pattern(cfg_pattern),
        .axi_tdata(axi_tdata), .axi_tvalid(axi_tvalid), .axi_tlast(axi_tlast),
        .axi_tready(axi_tready), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    // Data of global beat g within a run (beats numbered from 0 across packets).
    function automatic logic [31:0] exp_data(input int mode, input logic [31:0] pat,
                                             input int g, input int len);
        case (mode)
            0:       return 32'(g);
            1:       return 32'(g % len);
            2:       return pat;
            default: return 32'(1) << (g % 32);
        endcase
    endfunction

    task automatic scramble_cfg();
        cfg_mode     = 2'($urandom);
        cfg_len      = 16'($urandom);
        cfg_num_pkts = 16'($urandom);
        cfg_gap      = 8'($urandom);
        cfg_pattern  = $urandom;
    endtask

    // One complete run. stop_beat/poke_beat < 0 disable the mid-run stop / ignored-start pulse.
    task automatic run(input int mode, input int len, input int npk, input int gap,
                       input logic [31:0] pat, input int rdy_pct,
                       input int stop_beat, input int poke_beat);
        int g, total, n_exp, idle, cyc;
        bit newpkt, stall, first, stop_sent, poked;
        logic [31:0] hold_d;
        logic hold_l;
        n_exp = (npk != 0) ? npk : stop_beat / len + 1;
        total = n_exp * len;
        g = 0; idle = 0; cyc = 0;
        newpkt = 0; stall = 0; first = 1; stop_sent = 0; poked = 0;
        hold_d = '0; hold_l = 0;

        @(posedge axi_clk); #1;
        cfg_start = 1; cfg_mode = 2'(mode); cfg_len = 16'(len);
        cfg_num_pkts = 16'(npk); cfg_gap = 8'(gap); cfg_pattern = pat;
        @(posedge axi_clk); #1;
        cfg_start = 0;
        scramble_cfg();

        while (g < total && cyc < 2000) begin
            if (stop_beat >= 0 && !stop_sent && g == stop_beat && axi_tvalid) begin
                cfg_stop = 1; stop_sent = 1;
            end
            if (poke_beat >= 0 && !poked && g == poke_beat && axi_tvalid) begin
                cfg_start = 1; poked = 1;
            end
            axi_tready = ($urandom_range(99) < rdy_pct);
            @(negedge axi_clk);
            if (first) chk("start_latency", {62'd0, axi_tvalid, busy}, 64'd3);
            first = 0;
            chk("busy_run", busy, 1);
            chk("pkt_cnt_run", pkt_cnt, 64'(g / len));
            if (stall) begin
                chk("stall_valid", axi_tvalid, 1);
                chk("stall_hold", {axi_tdata, axi_tlast}, {hold_d, hold_l});
            end
            if (axi_tvalid) begin
                if (newpkt) begin
                    chk("gap_len", idle, gap);
                    newpkt = 0;
                end else if (idle != 0) begin
                    chk("bubble", idle, 0);
                end
                idle = 0;
                chk("tdata", axi_tdata, exp_data(mode, pat, g, len));
                chk("tlast", axi_tlast, 64'((g % len) == len - 1));
                stall  = !axi_tready;
                hold_d = axi_tdata;
                hold_l = axi_tlast;
                if (axi_tready) begin
                    if ((g % len) == len - 1) newpkt = 1;
                    g++;
                end
            end else begin
                idle++;
                stall = 0;
            end
            @(posedge axi_clk); #1;
            cfg_stop = 0; cfg_start = 0;
            cyc++;
        end
        chk("run_timeout", 64'(cyc < 2000), 1);
        axi_tready = 1'($urandom);
        @(negedge axi_clk);
        chk("end_valid", axi_tvalid, 0);
        chk("end_busy", busy, 0);
        chk("end_pkt_cnt", pkt_cnt, 64'(n_exp));
    endtask

    initial begin
        int k, rl, rn;

        // Reset state
        #1 axi_rst_L = 0;
        #1;
        chk("rst_valid", axi_tvalid, 0);
        chk("rst_last", axi_tlast, 0);
        chk("rst_data", axi_tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        repeat (3) @(posedge axi_clk);
        #1 axi_rst_L = 1;

        // Stop while idle must not leak into the next run
        @(posedge axi_clk); #1 cfg_stop = 1;
        @(posedge axi_clk); #1 cfg_stop = 0;

        // Free counter, back-to-back packets
        run(0, 4, 3, 0, 32'h0, 100, -1, -1);
        // Per-packet counter with gap; start while busy ignored
        run(1, 3, 2, 2, 32'h0, 100, -1, 2);
        // Back-pressure
        run(0, 8, 2, 0, 32'h0, 50, -1, 5);
        // Continuous walking one across the 32-bit wrap, stopped mid-packet 6
        run(3, 5, 0, 0, 32'h0, 100, 33, -1);
        // len=1 constant pattern
        run(2, 1, 4, 1, 32'hA5A5A5A5, 70, -1, 1);

        // Zero-length start rejected
        @(posedge axi_clk); #1;
        cfg_start = 1; cfg_len = 0; cfg_mode = 0; cfg_num_pkts = 1;
        @(posedge axi_clk); #1 cfg_start = 0;
        @(negedge axi_clk);
        chk("len0_busy", busy, 0);
        chk("len0_valid", axi_tvalid, 0);
        @(negedge axi_clk);
        chk("len0_busy2", busy, 0);

        // Stop during the gap ends the run on the next cycle
        @(posedge axi_clk); #1;
        cfg_start = 1; cfg_mode = 1; cfg_len = 2; cfg_num_pkts = 0; cfg_gap = 5;
        axi_tready = 1;
        @(posedge axi_clk); #1 cfg_start = 0;
        k = 0;
        while (!(axi_tvalid && axi_tlast) && k < 20) begin
            @(posedge axi_clk); #1; k++;
        end
        chk("gstop_reach", 64'(k < 20), 1);
        @(posedge axi_clk); #1;
        chk("gstop_in_gap", axi_tvalid, 0);
        cfg_stop = 1;
        @(posedge axi_clk); #1 cfg_stop = 0;
        @(negedge axi_clk);
        chk("gstop_busy", busy, 0);
        chk("gstop_valid", axi_tvalid, 0);
        chk("gstop_pkt_cnt", pkt_cnt, 1);

        // Randomized runs
        for (int r = 0; r < 4; r++) begin
            rl = int'($urandom_range(6, 1));
            rn = int'($urandom_range(3, 1));
            run(int'($urandom_range(3)), rl, rn, int'($urandom_range(3)), $urandom,
                int'($urandom_range(100, 40)), -1, int'($urandom_range(rl * rn - 1)));
        end

        // Async reset in the middle of a packet (beat 3 of 8)
        @(posedge axi_clk); #1;
        cfg_start = 1; cfg_mode = 0; cfg_len = 8; cfg_num_pkts = 0; cfg_gap = 0;
        axi_tready = 1;
        @(posedge axi_clk); #1 cfg_start = 0;
        repeat (3) @(posedge axi_clk);
        #1;
        chk("pre_rst_beat3", axi_tdata, 3);
        #2 axi_rst_L = 0;
        #1;
        chk("arst_valid", axi_tvalid, 0);
        chk("arst_last", axi_tlast, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pkt_cnt", pkt_cnt, 0);
        @(posedge axi_clk); #1 axi_rst_L = 1;
        run(0, 4, 1, 0, 32'h0, 100, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
